// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : LOAD/RUN/HALT run control and host/core arbitration onto a
//               single synchronous-read memory port, with host anti-starvation.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // host (loader/debug) requester
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_din,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  // core (fetcher/decoder) requester
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_din,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  // run control
  input  logic                  start,
  input  logic                  halt_req,
  output logic                  core_run,
  // shared memory port
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [1:0]            state
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
  logic             host_rv_q;
  logic             core_rv_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state  <= ST_LOAD;
      starve_cnt <= '0;
    end else begin
      cur_state  <= nxt_state;
      starve_cnt <= starve_nxt;
    end
  end

  // Grants are combinational so an access issues in the same cycle it is requested.
  always_comb begin
    nxt_state = cur_state;
    host_gnt  = 1'b0;
    core_gnt  = 1'b0;
    core_run  = 1'b0;
    case (cur_state)
      ST_LOAD, ST_HALT: begin
        host_gnt = host_req;
        if (start && !halt_req) nxt_state = ST_RUN;
      end
      ST_RUN: begin
        core_run = 1'b1;
        if (host_req && core_req) begin
          if (starve_cnt == CNT_MAX) host_gnt = 1'b1;
          else                       core_gnt = 1'b1;
        end else begin
          host_gnt = host_req;
          core_gnt = core_req;
        end
        if (halt_req) nxt_state = ST_HALT;
      end
      default: nxt_state = ST_LOAD;
    endcase
  end

  // Counts consecutive core wins while the host is kept waiting.
  always_comb begin
    starve_nxt = '0;
    if (host_req && core_gnt) starve_nxt = starve_cnt + 1'b1;
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (host_gnt) begin
      mem_we   = host_we;
      mem_addr = host_addr;
      mem_din  = host_din;
    end else if (core_gnt) begin
      mem_we   = core_we;
      mem_addr = core_addr;
      mem_din  = core_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_rv_q <= 1'b0;
      core_rv_q <= 1'b0;
    end else begin
      host_rv_q <= host_gnt & ~host_we;
      core_rv_q <= core_gnt & ~core_we;
    end
  end

  assign host_rvalid = host_rv_q;
  assign core_rvalid = core_rv_q;
  assign host_rdata  = host_rv_q ? mem_dout : '0;
  assign core_rdata  = core_rv_q ? mem_dout : '0;
  assign state       = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed + short random bench with a behavioural model of
//                  run control, arbitration and read return.
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SL = 4;
  localparam int M_LOAD = 0, M_RUN = 1, M_HALT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          host_req = 0, host_we = 0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_din = '0;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          core_req = 0, core_we = 0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_din = '0;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          start = 0, halt_req = 0;
  logic          core_run;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [1:0]    state;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_din(core_din),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .start(start), .halt_req(halt_req), .core_run(core_run),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .state(state)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory attached to the shared port.
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_din;
    mem_dout <= ram[mem_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: mode, host wait streak, pending read returns, shadow memory.
  int            m_mode;
  int            m_wait;
  bit            m_ph, m_pc;
  logic [DW-1:0] m_hd, m_cd;
  logic [DW-1:0] shadow [0:255];

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_LOAD; m_wait = 0; m_ph = 0; m_pc = 0; m_hd = '0; m_cd = '0;
    end else begin : cmp
      bit eh, ec;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      bit ew;
      if (m_mode != M_RUN) begin
        eh = host_req; ec = 0;
      end else if (host_req && core_req) begin
        eh = (m_wait >= SL); ec = !eh;
      end else begin
        eh = host_req; ec = core_req;
      end
      ew = 0; ea = '0; ed = '0;
      if (eh)      begin ew = host_we; ea = host_addr; ed = host_din; end
      else if (ec) begin ew = core_we; ea = core_addr; ed = core_din; end

      chk("host_gnt", host_gnt, eh);
      chk("core_gnt", core_gnt, ec);
      chk("state", state, m_mode);
      chk("core_run", core_run, m_mode == M_RUN);
      chk("mem_we", mem_we, ew);
      chk("mem_addr", mem_addr, ea);
      chk("mem_din", mem_din, ed);
      chk("host_rvalid", host_rvalid, m_ph);
      chk("core_rvalid", core_rvalid, m_pc);
      chk("host_rdata", host_rdata, m_ph ? m_hd : '0);
      chk("core_rdata", core_rdata, m_pc ? m_cd : '0);

      m_ph = eh && !host_we; m_hd = shadow[host_addr[7:0]];
      m_pc = ec && !core_we; m_cd = shadow[core_addr[7:0]];
      if (ew) shadow[ea[7:0]] = ed;
      m_wait = (host_req && ec) ? m_wait + 1 : 0;
      if (m_mode == M_RUN) begin
        if (halt_req) m_mode = M_HALT;
      end else if (start && !halt_req) m_mode = M_RUN;
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic sample(); @(negedge clk); #1; endtask

  task automatic host_set(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = r; host_we = w; host_addr = a; host_din = d;
  endtask
  task automatic core_set(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_req = r; core_we = w; core_addr = a; core_din = d;
  endtask

  logic [9:0] hp, cp;

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = '0; shadow[i] = '0; end
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_state", state, 0);
    chk("rst_core_run", core_run, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_core_rdata", core_rdata, 0);

    // LOAD: host write then read, core locked out
    host_set(1, 1, 16'h0010, 8'hA9); core_set(1, 0, 16'h0010, 8'h00);
    sample(); chk("load_wr_hgnt", host_gnt, 1); chk("load_wr_cgnt", core_gnt, 0);
    step(); host_set(1, 0, 16'h0010, 8'h00);
    sample(); chk("load_rd_hgnt", host_gnt, 1);
    step(); host_set(0, 0, 0, 0); core_set(0, 0, 0, 0);
    sample(); chk("load_rvalid", host_rvalid, 1); chk("load_rdata", host_rdata, 8'hA9);

    // start -> RUN, core read
    step(); start = 1;
    sample(); chk("start_still_load", state, 0);
    step(); start = 0; core_set(1, 0, 16'h0010, 8'h00);
    sample(); chk("run_state", state, 1); chk("run_core_run", core_run, 1); chk("run_cgnt", core_gnt, 1);
    step(); core_set(0, 0, 0, 0);
    sample(); chk("core_rvalid", core_rvalid, 1); chk("core_rdata", core_rdata, 8'hA9);

    // starvation: 4 core grants then 1 host, repeating
    step(); host_set(1, 0, 16'h0020, 0); core_set(1, 0, 16'h0030, 0);
    for (int i = 0; i < 10; i++) begin
      sample(); hp[i] = host_gnt; cp[i] = core_gnt;
      if (i < 9) step();
    end
    chk("starve_host_pattern", hp, 10'h210);
    chk("starve_core_pattern", cp, 10'h1EF);
    chk("no_double_grant", hp & cp, 0);

    // halt during core write
    step(); host_set(0, 0, 0, 0); core_set(1, 1, 16'h000C, 8'hFF); halt_req = 1;
    sample(); chk("halt_wr_cgnt", core_gnt, 1); chk("halt_wr_mem_we", mem_we, 1);
    step(); core_set(0, 0, 0, 0); halt_req = 0;
    sample(); chk("halt_state", state, 2); chk("halt_core_run", core_run, 0);
    step(); host_set(1, 0, 16'h000C, 0);
    sample(); chk("halt_hgnt", host_gnt, 1);
    step(); host_set(0, 0, 0, 0);
    sample(); chk("halt_rdata", host_rdata, 8'hFF);

    // start+halt in HALT stays; start alone resumes
    step(); start = 1; halt_req = 1;
    sample(); step(); start = 0; halt_req = 0;
    sample(); chk("halt_start_both", state, 2);
    step(); start = 1;
    sample(); step(); start = 0;
    sample(); chk("halt_resume", state, 1);

    // reset right after a host read grant
    step(); host_set(1, 0, 16'h000C, 0);
    sample(); chk("pre_rst_hgnt", host_gnt, 1);
    #1 reset = 1;
    #1 chk("async_rst_state", state, 0); chk("async_rst_core_run", core_run, 0);
    @(posedge clk); #1;
    chk("rst_drop_rvalid", host_rvalid, 0); chk("rst_drop_rdata", host_rdata, 0);
    host_set(0, 0, 0, 0); reset = 0;

    // host access right after release
    host_set(1, 1, 16'h0040, 8'h55);
    sample(); chk("post_rst_hgnt", host_gnt, 1);
    step(); host_set(1, 0, 16'h0040, 0);
    sample(); step(); host_set(0, 0, 0, 0);
    sample(); chk("post_rst_rdata", host_rdata, 8'h55);

    // short random mix, checked by the model every cycle
    for (int i = 0; i < 80; i++) begin
      step();
      host_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 15)), DW'($urandom));
      core_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 15)), DW'($urandom));
      start    = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 9) == 0);
    end
    step(); host_set(0, 0, 0, 0); core_set(0, 0, 0, 0); start = 0; halt_req = 0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, memory data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, maximum consecutive core grants while host waits in RUN.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have ports host_req, host_we, input, 1 each; host_addr, input, ADDR_WIDTH; host_din, input, DATA_WIDTH: external loader/debug access request.
REQ-007 SHALL have ports host_gnt, host_rvalid, output, 1 each; host_rdata, output, DATA_WIDTH.
REQ-008 SHALL have ports core_req, core_we, input, 1 each; core_addr, input, ADDR_WIDTH; core_din, input, DATA_WIDTH: fetcher/decoder access request.
REQ-009 SHALL have ports core_gnt, core_rvalid, output, 1 each; core_rdata, output, DATA_WIDTH.
REQ-010 SHALL have ports start, halt_req, input, 1 each: run control from host.
REQ-011 SHALL have port core_run, output, 1: core may execute; low holds fetcher/decoder.
REQ-012 SHALL have ports mem_we, output, 1; mem_addr, output, ADDR_WIDTH; mem_din, output, DATA_WIDTH; mem_dout, input, DATA_WIDTH: the single shared memory port (synchronous read, data valid cycle after address).
REQ-013 SHALL have port state, output, 2: LOAD=0, RUN=1, HALT=2.

Function
REQ-014 SHALL implement FSM states LOAD, RUN, HALT; 3 unused, recovers to LOAD next cycle.
REQ-015 LOAD: host_gnt = host_req; core_gnt = 0; core_run = 0.
REQ-016 LOAD with start=1 and halt_req=0 SHALL move to RUN next cycle; core_run asserts in the RUN cycle.
REQ-017 RUN: at most one grant per cycle; core_gnt priority over host_gnt when both request.
REQ-018 RUN: starve counter (width clog2(STARVE_LIMIT+1)) increments each cycle host_req=1 and core granted; clears when host granted or host_req=0.
REQ-019 RUN: when counter == STARVE_LIMIT and both request, host SHALL be granted, core_gnt=0, counter clears.
REQ-020 RUN: host_gnt=1 when host_req=1 and core_req=0.
REQ-021 RUN with halt_req=1 SHALL move to HALT next cycle; a grant issued in that cycle completes normally.
REQ-022 HALT: same as LOAD behaviour; start=1 with halt_req=0 returns to RUN; memory contents and core state untouched.
REQ-023 start in RUN ignored; halt_req in LOAD or HALT ignored; halt_req and start together: halt_req wins.
REQ-024 Grants combinational from current req/state; mem_we/mem_addr/mem_din mux from the granted requester; no grant: mem_we=0, mem_addr/mem_din=0.
REQ-025 Granted read (we=0) SHALL assert matching rvalid exactly 1 cycle later for 1 cycle, rdata = mem_dout; writes produce no rvalid.
REQ-026 host_rdata and core_rdata SHALL equal mem_dout when respective rvalid=1, 0 otherwise.
REQ-027 Requesters hold req/addr/din/we stable until gnt; gnt cycle consumes the request.
REQ-028 Back-to-back grants to the same requester SHALL be allowed every cycle (throughput 1 access/cycle).

Reset
REQ-029 reset=1 SHALL asynchronously force state=LOAD, starve counter=0, core_run=0, host_rvalid=core_rvalid=0, rdata outputs=0.
REQ-030 Reset mid-access SHALL drop any pending rvalid; no rvalid after reset release for pre-reset grants.
REQ-031 After reset release, host access in LOAD SHALL be available on the first clock edge.

Verification
REQ-032 Reset, LOAD: host writes 0xA9 to 0x0010, reads 0x0010 -> host_gnt each cycle, host_rvalid next cycle, host_rdata=0xA9; core_req=1 throughout -> core_gnt=0.
REQ-033 start pulse in LOAD -> state=RUN, core_run=1 next cycle; core read 0x0010 -> core_rvalid one cycle later, core_rdata=0xA9.
REQ-034 RUN, core_req and host_req held high -> 4 core grants, 5th cycle host_gnt=1, pattern repeats; no cycle with both gnt high.
REQ-035 RUN, halt_req during core write 0xFF to 0x000C -> write completes, state=HALT, core_run=0; host read 0x000C returns 0xFF.
REQ-036 reset asserted cycle after host read grant -> host_rvalid stays 0, state=LOAD, core_run=0 immediately (asynchronous).
REQ-037 start and halt_req together in HALT -> remains HALT; start alone -> RUN.
